// File: rtl/mips_trace_monitor.sv
// Trace buffer and PC breakpoint monitor for the mips_soc core observation bus.
// Define MIPS_TRACE_DM_EN to add the wd_dm/rd_dm fields to each trace record.
module mips_trace_monitor #(
  parameter int DEPTH  = 16,
  parameter int NUM_BP = 2,
`ifdef MIPS_TRACE_DM_EN
  localparam int REC_W = 161,
`else
  localparam int REC_W = 97,
`endif
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic                  resume,
  input  logic [31:0]           pc_current,
  input  logic [31:0]           instr,
  input  logic [31:0]           alu_out,
  input  logic [31:0]           wd_dm,
  input  logic [31:0]           rd_dm,
  input  logic                  we_dm,
  input  logic [32*NUM_BP-1:0]  bp_addr,
  input  logic [NUM_BP-1:0]     bp_valid,
  output logic                  halt,
  output logic [NUM_BP-1:0]     halt_cause,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [REC_W-1:0]      rd_data,
  output logic [AW:0]           count,
  output logic                  overflow
);

  // state     | meaning
  // S_IDLE    | not tracing; en=1 samples this cycle and moves to S_CAPTURE
  // S_CAPTURE | recording one record per cycle, breakpoints armed
  // S_HALTED  | breakpoint hit, halt asserted, buffer frozen until resume
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_HALTED} state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t              state, state_nxt;
  logic                step_past;
  logic                cap_act;
  logic                hit;
  logic [NUM_BP-1:0]   match;
  logic                push, pop, full;
  logic [AW-1:0]       head, tail;
  logic [REC_W-1:0]    rec;
  logic [REC_W-1:0]    mem [DEPTH];

`ifdef MIPS_TRACE_DM_EN
  assign rec = {we_dm, pc_current, instr, alu_out, wd_dm, rd_dm};
`else
  logic unused_dm;
  assign unused_dm = ^{wd_dm, rd_dm};
  assign rec = {we_dm, pc_current, instr, alu_out};
`endif

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = bp_valid[i] && (pc_current == bp_addr[32*i +: 32]);
    end
  end

  // The first capture cycle after a resume skips the compare so the core can step off the breakpoint.
  assign cap_act = en && (state != S_HALTED);
  assign hit     = cap_act && !step_past && (|match);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (hit)     state_nxt = S_HALTED;
        else if (en) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (!en)      state_nxt = S_IDLE;
        else if (hit) state_nxt = S_HALTED;
      end
      S_HALTED: begin
        if (resume) state_nxt = en ? S_CAPTURE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      step_past  <= 1'b0;
      halt_cause <= '0;
    end else begin
      state <= state_nxt;
      if (hit) halt_cause <= match;
      if (state == S_HALTED && resume) step_past <= 1'b1;
      else if (cap_act)                step_past <= 1'b0;
    end
  end

  assign halt = (state == S_HALTED);

  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign push     = cap_act;

  always_ff @(posedge clk) begin
    if (!clear && push) mem[tail] <= rec;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + AW'(1);
      // A push into a full buffer with no pop drops the oldest record.
      if (pop || (push && full)) head <= head + AW'(1);
      if (push && !pop && full) overflow <= 1'b1;
      if (push && !pop && !full)  count <= count + (AW+1)'(1);
      else if (pop && !push)      count <= count - (AW+1)'(1);
    end
  end

  assign rd_data = rd_valid ? mem[head] : '0;

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Directed bench for mips_trace_monitor: a queue models buffer contents,
// a negedge monitor compares every popped record against it.
module tb_mips_trace_monitor;
  localparam int DEPTH  = 16;
  localparam int NUM_BP = 2;
`ifdef MIPS_TRACE_DM_EN
  localparam int REC_W = 161;
`else
  localparam int REC_W = 97;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              en, clear, resume, we_dm, rd_ready;
  logic [31:0]       pc_current, instr, alu_out, wd_dm, rd_dm;
  logic [32*NUM_BP-1:0] bp_addr;
  logic [NUM_BP-1:0] bp_valid;
  logic              halt, rd_valid, overflow;
  logic [NUM_BP-1:0] halt_cause;
  logic [REC_W-1:0]  rd_data;
  logic [CW-1:0]     count;

  int n_total = 0;
  int n_pass  = 0;
  bit mon_en  = 1'b0;
  logic [REC_W-1:0] model [$];

  mips_trace_monitor #(.DEPTH(DEPTH), .NUM_BP(NUM_BP)) dut (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .resume(resume),
    .pc_current(pc_current), .instr(instr), .alu_out(alu_out),
    .wd_dm(wd_dm), .rd_dm(rd_dm), .we_dm(we_dm),
    .bp_addr(bp_addr), .bp_valid(bp_valid),
    .halt(halt), .halt_cause(halt_cause),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] p);
`ifdef MIPS_TRACE_DM_EN
    return {p[2], p, p ^ 32'hA5A5_0000, p + 32'h1000, ~p, p << 1};
`else
    return {p[2], p, p ^ 32'hA5A5_0000, p + 32'h1000};
`endif
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // One clock of stimulus; the model is updated after the edge commits.
  task automatic step(input logic e, input logic [31:0] p, input logic rdy,
                      input logic psh, input logic rsm = 1'b0, input logic clr = 1'b0);
    bit popped;
    en = e; pc_current = p; we_dm = p[2];
    instr = p ^ 32'hA5A5_0000; alu_out = p + 32'h1000; wd_dm = ~p; rd_dm = p << 1;
    rd_ready = rdy; resume = rsm; clear = clr;
    popped = rdy && (model.size() != 0);
    @(posedge clk); #1;
    if (clr) model.delete();
    else if (psh) begin
      if (!popped && model.size() == DEPTH) void'(model.pop_front());
      model.push_back(mk_rec(p));
    end
    resume = 1'b0; clear = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rd_valid", 256'(rd_valid), 256'(model.size() != 0));
      if (rd_valid && rd_ready) begin
        if (model.size() == 0) chk("sb_unexpected_pop", 256'(1), 256'(0));
        else chk("sb_record", 256'(rd_data), 256'(model.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; clear = 1'b0; resume = 1'b0; rd_ready = 1'b0;
    pc_current = '0; instr = '0; alu_out = '0; wd_dm = '0; rd_dm = '0; we_dm = 1'b0;
    bp_addr = '0; bp_valid = '0;
    #2;
    chk("rst_halt", 256'(halt), 256'(0));
    chk("rst_cause", 256'(halt_cause), 256'(0));
    chk("rst_rd_valid", 256'(rd_valid), 256'(0));
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_overflow", 256'(overflow), 256'(0));
    chk("rst_rd_data", 256'(rd_data), 256'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // three captures, then drain oldest-first
    step(1, 32'h0, 0, 1);
    step(1, 32'h4, 0, 1);
    step(1, 32'h8, 0, 1);
    chk("cap3_count", 256'(count), 256'(3));
    chk("cap3_head_pc", 256'(rd_data[REC_W-2 -: 32]), 256'(32'h0));
    for (int i = 0; i < 3; i++) step(0, 32'h0, 1, 0);
    chk("drain_rd_valid", 256'(rd_valid), 256'(0));
    chk("drain_count", 256'(count), 256'(0));

    // fill, push+pop while full, then overwrite
    step(0, 32'h0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 32'(4*i), 0, 1);
    chk("full_count", 256'(count), 256'(16));
    chk("full_overflow", 256'(overflow), 256'(0));
    step(1, 32'h40, 1, 1);
    chk("pushpop_count", 256'(count), 256'(16));
    chk("pushpop_overflow", 256'(overflow), 256'(0));
    for (int i = 0; i < 3; i++) step(1, 32'(32'h44 + 4*i), 0, 1);
    chk("ovf_count", 256'(count), 256'(16));
    chk("ovf_overflow", 256'(overflow), 256'(1));
    chk("ovf_head_pc", 256'(rd_data[REC_W-2 -: 32]), 256'(32'h10));
    step(0, 32'h0, 0, 0, 0, 1);
    chk("clear_count", 256'(count), 256'(0));
    chk("clear_overflow", 256'(overflow), 256'(0));

    // single breakpoint, freeze, resume step-past, re-hit
    bp_addr = {32'h0, 32'h100}; bp_valid = 2'b01;
    step(1, 32'hF8, 0, 1);
    step(1, 32'hFC, 0, 1);
    chk("pre_hit_halt", 256'(halt), 256'(0));
    step(1, 32'h100, 0, 1);
    chk("hit_halt", 256'(halt), 256'(1));
    chk("hit_cause", 256'(halt_cause), 256'(2'b01));
    chk("hit_count", 256'(count), 256'(3));
    step(1, 32'h104, 0, 0);
    step(1, 32'h108, 0, 0);
    chk("frozen_count", 256'(count), 256'(3));
    chk("frozen_halt", 256'(halt), 256'(1));
    step(1, 32'h100, 0, 0, 1);
    chk("resume_halt", 256'(halt), 256'(0));
    step(1, 32'h100, 0, 1);
    chk("steppast_halt", 256'(halt), 256'(0));
    step(1, 32'h104, 0, 1);
    step(1, 32'h100, 0, 1);
    chk("rehit_halt", 256'(halt), 256'(1));
    chk("rehit_count", 256'(count), 256'(6));
    for (int i = 0; i < 6; i++) step(1, 32'h200, 1, 0);
    chk("halted_drain_valid", 256'(rd_valid), 256'(0));

    // both comparators match together
    bp_addr = {32'h20, 32'h20}; bp_valid = 2'b11;
    step(0, 32'h0, 0, 0, 1);
    chk("resume_idle_halt", 256'(halt), 256'(0));
    for (int i = 0; i < 5; i++) step(1, 32'(32'h10 + 4*i), 0, 1);
    chk("dual_halt", 256'(halt), 256'(1));
    chk("dual_cause", 256'(halt_cause), 256'(2'b11));
    chk("dual_count", 256'(count), 256'(5));

    // asynchronous reset mid-operation
    mon_en = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    model.delete();
    chk("arst_halt", 256'(halt), 256'(0));
    chk("arst_cause", 256'(halt_cause), 256'(0));
    chk("arst_rd_valid", 256'(rd_valid), 256'(0));
    chk("arst_count", 256'(count), 256'(0));
    chk("arst_overflow", 256'(overflow), 256'(0));
    chk("arst_rd_data", 256'(rd_data), 256'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    step(0, 32'h20, 1, 0);
    chk("post_rst_halt", 256'(halt), 256'(0));
    chk("post_rst_count", 256'(count), 256'(0));
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
